// File: rtl/wb_port_arbiter.sv
// wb_port_arbiter: arbitrates the WB-stage regfile write port between the pipeline and a 2-entry aux result FIFO.
// Optional starvation limiter enabled by defining WB_ARB_STARVE_EN.
module wb_port_arbiter #(
    parameter int STARVE_LIMIT = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        pipe_valid_in,
    input  logic [3:0]  pipe_we_in,
    input  logic [4:0]  pipe_wnum_in,
    input  logic [31:0] pipe_wdata_in,
    input  logic [31:0] pipe_pc_in,
    output logic        pipe_stall_out,
    input  logic        aux_valid_in,
    output logic        aux_ready_out,
    input  logic [4:0]  aux_wnum_in,
    input  logic [31:0] aux_wdata_in,
    input  logic [31:0] aux_pc_in,
    input  logic        flush_in,
    output logic [3:0]  rf_we_out,
    output logic [4:0]  rf_wnum_out,
    output logic [31:0] rf_wdata_out,
    output logic [31:0] rf_pc_out,
    output logic        rf_src_out
);
    logic [4:0]  f_wnum  [2];
    logic [31:0] f_wdata [2];
    logic [31:0] f_pc    [2];
    logic        rd_ptr, wr_ptr;
    logic [1:0]  count;
    logic        pipe_need, nonempty, hazard, starve_hit, grant_aux, grant_pipe, push;

    assign aux_ready_out = count != 2'd2;
    assign nonempty      = count != 2'd0;
    assign pipe_need     = pipe_valid_in && pipe_we_in != 4'd0 && pipe_wnum_in != 5'd0;
    assign push          = aux_valid_in && aux_ready_out && !flush_in;

    // Only entries already stored are compared; a same-cycle push is seen next cycle.
    always_comb begin
        hazard = pipe_need && ((count == 2'd2 && (f_wnum[0] == pipe_wnum_in || f_wnum[1] == pipe_wnum_in))
                 || (count == 2'd1 && f_wnum[rd_ptr] == pipe_wnum_in));
        grant_aux      = !flush_in && nonempty && (hazard || starve_hit || !pipe_need);
        grant_pipe     = !flush_in && pipe_need && !grant_aux;
        pipe_stall_out = !flush_in && pipe_need && grant_aux;
    end

`ifdef WB_ARB_STARVE_EN
    localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);
    logic [3:0] starve_cnt;

    assign starve_hit = nonempty && starve_cnt == LIMIT;

    always_ff @(posedge clk) begin
        if (!rst_n || flush_in || !nonempty || grant_aux)
            starve_cnt <= 4'd0;
        else if (starve_cnt != LIMIT)
            starve_cnt <= starve_cnt + 4'd1;
    end
`else
    localparam logic [3:0] unused_limit = 4'(STARVE_LIMIT);
    assign starve_hit = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rd_ptr <= 1'b0;
            wr_ptr <= 1'b0;
            count  <= 2'd0;
            for (int i = 0; i < 2; i++) begin
                f_wnum[i]  <= 5'd0;
                f_wdata[i] <= 32'd0;
                f_pc[i]    <= 32'd0;
            end
        end else if (flush_in) begin
            rd_ptr <= 1'b0;
            wr_ptr <= 1'b0;
            count  <= 2'd0;
        end else begin
            if (push) begin
                f_wnum[wr_ptr]  <= aux_wnum_in;
                f_wdata[wr_ptr] <= aux_wdata_in;
                f_pc[wr_ptr]    <= aux_pc_in;
                wr_ptr          <= ~wr_ptr;
            end
            if (grant_aux)
                rd_ptr <= ~rd_ptr;
            count <= count + {1'b0, push} - {1'b0, grant_aux};
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rf_we_out    <= 4'd0;
            rf_wnum_out  <= 5'd0;
            rf_wdata_out <= 32'd0;
            rf_pc_out    <= 32'd0;
            rf_src_out   <= 1'b0;
        end else if (grant_pipe) begin
            rf_we_out    <= pipe_we_in;
            rf_wnum_out  <= pipe_wnum_in;
            rf_wdata_out <= pipe_wdata_in;
            rf_pc_out    <= pipe_pc_in;
            rf_src_out   <= 1'b0;
        end else if (grant_aux) begin
            // Aux writes to r0 are drained from the FIFO but never reach the regfile.
            rf_we_out    <= f_wnum[rd_ptr] == 5'd0 ? 4'd0 : 4'hf;
            rf_wnum_out  <= f_wnum[rd_ptr];
            rf_wdata_out <= f_wdata[rd_ptr];
            rf_pc_out    <= f_pc[rd_ptr];
            rf_src_out   <= 1'b1;
        end else begin
            rf_we_out    <= 4'd0;
        end
    end
endmodule

// File: doc/wb_port_arbiter.md
WB_PORT_ARBITER -- requirements
Module: wb_port_arbiter

Interface
REQ-001 SHALL have parameter STARVE_LIMIT, default 4, meaning consecutive cycles aux may wait before pipe is stalled (range 1..15).
REQ-002 SHALL have ports: clk  in  1  clock; rst_n  in  1  synchronous active-low reset.
REQ-003 SHALL have pipe_valid_in  in  1, pipe_we_in  in  4, pipe_wnum_in  in  5, pipe_wdata_in  in  32, pipe_pc_in  in  32: WB-stage write request.
REQ-004 SHALL have pipe_stall_out  out  1: WB must hold its current beat this cycle.
REQ-005 SHALL have aux_valid_in  in  1, aux_ready_out  out  1, aux_wnum_in  in  5, aux_wdata_in  in  32, aux_pc_in  in  32: multi-cycle unit (mul/div) result handshake.
REQ-006 SHALL have flush_in  in  1: exception/ERET flush (driven from ClrStpJmp).
REQ-007 SHALL have rf_we_out  out  4, rf_wnum_out  out  5, rf_wdata_out  out  32, rf_pc_out  out  32, rf_src_out  out  1 (0 pipe, 1 aux): registered regfile write port and debug trace.

Function
REQ-008 SHALL buffer aux results in a 2-entry FIFO; aux beat accepted when aux_valid_in && aux_ready_out.
REQ-009 SHALL drive aux_ready_out = 1 iff FIFO not full (combinational from registered count only).
REQ-010 SHALL treat a pipe beat as needing the port iff pipe_valid_in && pipe_we_in != 0 && pipe_wnum_in != 0.
REQ-011 SHALL grant, per cycle, exactly one of: pipe (needs port, not stalled), aux FIFO head (FIFO non-empty), or none.
REQ-012 SHALL stall pipe (pipe_stall_out=1) and grant aux head when pipe needs port and any FIFO entry has wnum == pipe_wnum_in (write-order hazard).
REQ-013 SHALL stall pipe and grant aux head when starvation counter == STARVE_LIMIT.
REQ-014 SHALL otherwise grant pipe when it needs port, else aux head when FIFO non-empty.
REQ-015 SHALL never assert pipe_stall_out when pipe does not need the port.
REQ-016 SHALL increment a 4-bit starvation counter each cycle FIFO non-empty and aux not granted, saturating at STARVE_LIMIT; clear it on aux grant or FIFO empty.
REQ-017 SHALL register granted beat with 1-cycle latency: pipe -> rf_we_out=pipe_we_in, aux -> rf_we_out=4'b1111; none -> rf_we_out=0, other rf outputs hold.
REQ-018 SHALL force rf_we_out=0 for any granted beat with wnum 0 (aux wnum 0 accepted and discarded).
REQ-019 SHALL allow simultaneous enqueue and dequeue in one cycle; count unchanged, order preserved.
REQ-020 SHALL include an entry accepted this cycle in hazard checks from the next cycle only.
REQ-021 SHALL, on flush_in=1, empty FIFO, clear counter, grant none, deassert pipe_stall_out, and drop any aux beat offered that cycle (aux_ready_out still reflects pre-flush count).
REQ-022 SHALL keep FIFO pointers 1-bit wrapping, count 2-bit in 0..2.

Reset
REQ-023 SHALL on rst_n=0 at clk edge clear FIFO, pointers, count, counter.
REQ-024 SHALL reset rf_we_out=0, rf_wnum_out=0, rf_wdata_out=0, rf_pc_out=0, rf_src_out=0.
REQ-025 SHALL hold pipe_stall_out=0 and aux_ready_out=1 out of reset; reset mid-operation discards buffered entries.

Configuration
REQ-026 SHALL support macro WB_ARB_STARVE_EN: defined -> REQ-013/REQ-016 active; undefined -> no counter, aux granted only when pipe does not need port or on hazard (REQ-012).

Verification
REQ-027 Pipe only: pipe we=1111 wnum=3 data=0x11 pc=0xBFC00000 -> next cycle rf_we=1111 wnum=3 data=0x11 src=0, no stall.
REQ-028 Aux idle port: aux wnum=5 data=0xAA, pipe idle -> accepted, granted next cycle, output rf_we=1111 wnum=5 src=1 one cycle later.
REQ-029 Hazard: FIFO holds wnum=7, pipe writes wnum=7 -> stall=1, aux out first, pipe write follows next cycle.
REQ-030 Starvation (EN, limit 4): FIFO 1 entry, pipe writes every cycle to wnum 9 -> 4 pipe grants, then stall=1 for one cycle with aux grant; without macro pipe never stalls.
REQ-031 Full/flush: push 2 aux entries while pipe busy -> aux_ready_out=0; assert flush_in -> FIFO empty, aux_ready_out=1 next cycle, no aux write emitted.
REQ-032 Reset mid-operation with 2 buffered entries -> all outputs reset values, no buffered write ever emitted.
